// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier with IDLE/CALC/DONE sequencing, one partial product per clock.
// Optional build macro MUL_SEQ_EARLY_TERM_EN ends CALC as soon as no multiplier bits remain.
module mul_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;

    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier_next;
    logic                 last_step;

    function automatic logic [2*WIDTH-1:0] pp_add(input logic [2*WIDTH-1:0] a,
                                                  input logic [2*WIDTH-1:0] m,
                                                  input logic             sel);
        return sel ? (a + m) : a;
    endfunction

    always_comb begin
        acc_next    = pp_add(acc, mcand, mplier[0]);
        mplier_next = mplier >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
        last_step   = (cnt == CNT_W'(WIDTH - 1)) || (mplier_next == '0);
`else
        last_step   = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, op_a};
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + CNT_W'(1);
                    // Load the final sum on entry to DONE so product is already valid while done is high.
                    if (last_step) begin
                        product <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: the driver queues expected products and completion cycles,
// an independent monitor checks every done pulse, held product value and reset behaviour.
module tb_mul_seq_ctrl;

    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic             rst_seen = 1'b1;
    logic [2*W-1:0]   hold_exp = '0;

    mul_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Number of CALC cycles the design should spend for a given multiplier.
    function automatic int calc_len(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
        int n;
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return n;
`else
        return (b == '0) ? W : W;
`endif
    endfunction

    // Monitor: reset state, each done pulse against the queue head, and product hold.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_product", 64'(product), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            hold_exp = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: product %0h, none expected", cyc, product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 64'(product), 64'(e.p));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                hold_exp = e.p;
            end
        end else begin
            check("product_hold", 64'(product), 64'(hold_exp));
        end
    end

    // Called at a negedge; drives start for one cycle. Accepted requests are queued.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_p, input bit accept);
        exp_t e;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        if (accept) begin
            e.p   = exp_p;
            e.cyc = cyc + calc_len(b) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int len;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
        end

        // Basic multiply with busy profile across the whole operation.
        issue(16'd2001, 16'd4001, 32'h007A2971, 1'b1);
        len = calc_len(16'd4001);
        for (int i = 0; i <= len; i++) begin
            check("busy_active", 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("busy_after", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        // Maximum operands, then zero multiplicand.
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        repeat (20) @(negedge clk);
        issue(16'h0000, 16'hFFFF, 32'h00000000, 1'b1);
        repeat (20) @(negedge clk);

        // Busy lockout: second start during CALC is dropped, start right after DONE is taken.
        issue(16'd7, 16'd9, 32'd63, 1'b1);
        repeat (4) @(negedge clk);
        issue(16'd3, 16'd3, 32'd0, 1'b0);
        repeat (12) @(negedge clk);
        issue(16'd3, 16'd3, 32'd9, 1'b1);
        repeat (20) @(negedge clk);

        // Reset in the middle of a multiply discards it.
        issue(16'd5001, 16'd3001, 32'h00E50101, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(16'd5001, 16'd3001, 32'h00E50101, 1'b1);
        repeat (20) @(negedge clk);

`ifdef MUL_SEQ_EARLY_TERM_EN
        issue(16'd5001, 16'd1, 32'd5001, 1'b1);
        repeat (4) @(negedge clk);
        issue(16'd123, 16'd0, 32'd0, 1'b1);
        repeat (4) @(negedge clk);
        issue(16'd2, 16'h8000, 32'h00010000, 1'b1);
        repeat (20) @(negedge clk);
`endif

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
